// File: rtl/fault_event_logger_if.sv
// Host-side read port of the fault event logger: FWFT head entry, pop strobe and occupancy.
interface fault_event_logger_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          rd_en;
  logic          rd_valid;
  logic [2:0]    rd_sev;
  logic [1:0]    rd_chan;
  logic [7:0]    rd_ts;
  logic [CW-1:0] count;

  modport master (
    output rd_en,
    input  rd_valid, rd_sev, rd_chan, rd_ts, count
  );

  modport slave (
    input  rd_en,
    output rd_valid, rd_sev, rd_chan, rd_ts, count
  );
endinterface

// File: rtl/fault_event_logger.sv
// Turns new non-zero classifier reports into queued events, tracks per-channel peak severity, raises alarm.
// Optional macro FAULT_TIMESTAMP_EN adds an 8-bit free-running timestamp stored with each entry.
module fault_event_logger #(
  parameter int DEPTH       = 8,
  parameter int ALARM_LEVEL = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          sev_in,
  input  logic [1:0]          chan_in,
  input  logic                clr,
  input  logic [1:0]          clr_chan,
  fault_event_logger_if.slave rd_bus,
  output logic                overflow,
  output logic [11:0]         peak_sev,
  output logic                alarm
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [2:0] sev;
    logic [1:0] chan;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_idx;
  logic [CW-1:0] count_q;
  logic [4:0]    prev;
  logic [2:0]    peak [4];

  logic [2:0] sev_c;
  logic       evt;
  logic       pop;
  logic       full;
  logic       push;
  logic       drop;

  assign sev_c = (sev_in > 3'd4) ? 3'd4 : sev_in;
  assign evt   = (sev_c != 3'd0) && ({sev_c, chan_in} != prev);
  assign pop   = rd_bus.rd_en && (count_q != '0);
  assign full  = (count_q == CW'(DEPTH));
  assign push  = evt && (!full || pop);
  assign drop  = evt && full && !pop;

  // While empty the slot just behind rd_ptr holds the last popped entry, so the head output holds.
  assign rd_idx = (count_q == '0) ? (rd_ptr - AW'(1)) : rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      prev     <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      prev <= {sev_c, chan_in};
      if (push) begin
        mem[wr_ptr] <= '{sev: sev_c, chan: chan_in};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop)     overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;
    end
  end

  // An event on the cleared channel wins: the peak restarts at the event severity.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 4; c++) peak[c] <= '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (evt && (chan_in == 2'(c))) begin
          if (clr && (clr_chan == 2'(c)))  peak[c] <= sev_c;
          else if (sev_c > peak[c])        peak[c] <= sev_c;
        end else if (clr && (clr_chan == 2'(c))) begin
          peak[c] <= '0;
        end
      end
    end
  end

`ifdef FAULT_TIMESTAMP_EN
  logic [7:0] ts_cnt;
  logic [7:0] ts_mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) ts_mem[i] <= '0;
    end else begin
      ts_cnt <= ts_cnt + 8'd1;
      if (push) ts_mem[wr_ptr] <= ts_cnt;
    end
  end

  assign rd_bus.rd_ts = ts_mem[rd_idx];
`else
  assign rd_bus.rd_ts = 8'd0;
`endif

  assign rd_bus.rd_valid = (count_q != '0);
  assign rd_bus.rd_sev   = mem[rd_idx].sev;
  assign rd_bus.rd_chan  = mem[rd_idx].chan;
  assign rd_bus.count    = count_q;

  always_comb begin
    alarm = 1'b0;
    for (int c = 0; c < 4; c++) begin
      peak_sev[3*c +: 3] = peak[c];
      if (peak[c] >= 3'(ALARM_LEVEL)) alarm = 1'b1;
    end
  end
endmodule

// File: tb/tb_fault_event_logger.sv
// Randomized and directed bench for fault_event_logger against a queue-based reference model.
module tb_fault_event_logger;
  localparam int DEPTH       = 8;
  localparam int ALARM_LEVEL = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  sev_in = '0;
  logic [1:0]  chan_in = '0;
  logic        clr = 1'b0;
  logic [1:0]  clr_chan = '0;
  logic        overflow;
  logic [11:0] peak_sev;
  logic        alarm;

  fault_event_logger_if #(.DEPTH(DEPTH)) rd_bus ();

  fault_event_logger #(.DEPTH(DEPTH), .ALARM_LEVEL(ALARM_LEVEL)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sev_in   (sev_in),
    .chan_in  (chan_in),
    .clr      (clr),
    .clr_chan (clr_chan),
    .rd_bus   (rd_bus),
    .overflow (overflow),
    .peak_sev (peak_sev),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sev;
    int chan;
    int ts;
  } ent_t;

  ent_t q[$];
  ent_t m_last;
  int   m_prev_sev, m_prev_chan;
  int   m_peak[4];
  bit   m_ovf;
  int   m_ts;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    q.delete();
    m_last      = '{0, 0, 0};
    m_prev_sev  = 0;
    m_prev_chan = 0;
    for (int c = 0; c < 4; c++) m_peak[c] = 0;
    m_ovf = 0;
    m_ts  = 0;
  endfunction

  // One clock edge of the logger, straight from its rules.
  function automatic void m_edge(int s, int c, bit rd, bit cl, int cc);
    int   sc;
    bit   evt, pop, full;
    ent_t e;
    sc   = (s > 4) ? 4 : s;
    evt  = (sc != 0) && !(sc == m_prev_sev && c == m_prev_chan);
    pop  = rd && (q.size() > 0);
    full = (q.size() == DEPTH);
    if (cl) m_ovf = 0;
    if (pop) m_last = q.pop_front();
    if (evt) begin
      if (full && !pop) m_ovf = 1;
      else begin
        e = '{sc, c, m_ts};
        q.push_back(e);
      end
    end
    if (cl) m_peak[cc] = 0;
    if (evt && sc > m_peak[c]) m_peak[c] = sc;
    m_prev_sev  = sc;
    m_prev_chan = c;
    m_ts        = (m_ts + 1) % 256;
  endfunction

  task automatic check_all(input string tag);
    ent_t        h;
    logic [11:0] pk;
    bit          al;
    h  = (q.size() > 0) ? q[0] : m_last;
    al = 0;
    for (int c = 0; c < 4; c++) begin
      pk[3*c +: 3] = 3'(m_peak[c]);
      if (m_peak[c] >= ALARM_LEVEL) al = 1;
    end
    check({tag, ".rd_valid"}, 32'(rd_bus.rd_valid), 32'(q.size() > 0));
    check({tag, ".count"},    32'(rd_bus.count),    32'(q.size()));
    check({tag, ".rd_sev"},   32'(rd_bus.rd_sev),   32'(h.sev));
    check({tag, ".rd_chan"},  32'(rd_bus.rd_chan),  32'(h.chan));
`ifdef FAULT_TIMESTAMP_EN
    check({tag, ".rd_ts"},    32'(rd_bus.rd_ts),    32'(h.ts));
`else
    check({tag, ".rd_ts"},    32'(rd_bus.rd_ts),    32'(0));
`endif
    check({tag, ".overflow"}, 32'(overflow),        32'(m_ovf));
    check({tag, ".peak_sev"}, 32'(peak_sev),        32'(pk));
    check({tag, ".alarm"},    32'(alarm),           32'(al));
  endtask

  task automatic step(input string tag, input logic [2:0] s, input logic [1:0] c,
                      input logic rd, input logic cl, input logic [1:0] cc);
    sev_in       = s;
    chan_in      = c;
    rd_bus.rd_en = rd;
    clr          = cl;
    clr_chan     = cc;
    @(posedge clk);
    m_edge(int'(s), int'(c), rd, cl, int'(cc));
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 3'd0, 2'd0, 1'b0, 1'b0, 2'd0);
  endtask

  // Asynchronous assertion checked before any edge; release on a falling edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    m_reset();
    check_all("rst");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int rd_pct;
    int ls, lc, s, c;
    rd_bus.rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // held report produces one event
    for (int i = 0; i < 10; i++) step("hold", 3'd3, 2'd2, 1'b0, 1'b0, 2'd0);
    check("hold.count1", 32'(rd_bus.count), 32'd1);
    check("hold.peak2",  32'(peak_sev[8:6]), 32'd3);
    check("hold.alarm",  32'(alarm), 32'd1);
    step("hold", 3'd0, 2'd0, 1'b1, 1'b0, 2'd0);

    // repeat after gap, clamp
    step("seq", 3'd1, 2'd0, 1'b0, 1'b0, 2'd0);
    step("seq", 3'd0, 2'd0, 1'b0, 1'b0, 2'd0);
    step("seq", 3'd1, 2'd0, 1'b0, 1'b0, 2'd0);
    step("seq", 3'd6, 2'd1, 1'b0, 1'b0, 2'd0);
    check("seq.count3", 32'(rd_bus.count), 32'd3);
    check("seq.peak1",  32'(peak_sev[5:3]), 32'd4);
    for (int i = 0; i < 3; i++) step("seqpop", 3'd0, 2'd0, 1'b1, 1'b0, 2'd0);
    check("seq.empty", 32'(rd_bus.rd_valid), 32'd0);

    // fill past DEPTH
    do_reset();
    for (int i = 0; i < 10; i++) step("fill", 3'((i % 4) + 1), 2'(i % 4), 1'b0, 1'b0, 2'd0);
    check("fill.count8", 32'(rd_bus.count), 32'd8);
    check("fill.ovf",    32'(overflow), 32'd1);
    step("fullpp", 3'd2, 2'd3, 1'b1, 1'b0, 2'd0);
    check("fullpp.count8", 32'(rd_bus.count), 32'd8);
    check("fullpp.ovf",    32'(overflow), 32'd1);
    for (int i = 0; i < 9; i++) step("drain", 3'd0, 2'd0, 1'b1, 1'b0, 2'd0);

    // clear peak and overflow
    do_reset();
    step("clr", 3'd4, 2'd3, 1'b0, 1'b0, 2'd0);
    check("clr.alarm_on", 32'(alarm), 32'd1);
    step("clr", 3'd0, 2'd0, 1'b0, 1'b1, 2'd3);
    check("clr.peak3", 32'(peak_sev[11:9]), 32'd0);
    check("clr.alarm_off", 32'(alarm), 32'd0);
    step("clrevt", 3'd2, 2'd3, 1'b0, 1'b1, 2'd3);
    check("clrevt.peak3", 32'(peak_sev[11:9]), 32'd2);

    // timestamps at edges 5 and 260
    do_reset();
    idle("ts", 5);
    step("ts", 3'd1, 2'd0, 1'b0, 1'b0, 2'd0);
`ifdef FAULT_TIMESTAMP_EN
    check("ts.first", 32'(rd_bus.rd_ts), 32'd5);
`else
    check("ts.first", 32'(rd_bus.rd_ts), 32'd0);
`endif
    idle("ts", 254);
    step("ts", 3'd2, 2'd1, 1'b1, 1'b0, 2'd0);
`ifdef FAULT_TIMESTAMP_EN
    check("ts.wrap", 32'(rd_bus.rd_ts), 32'd4);
`else
    check("ts.wrap", 32'(rd_bus.rd_ts), 32'd0);
`endif

    // randomized traffic
    do_reset();
    ls = 0;
    lc = 0;
    rd_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rd_pct = (($urandom_range(0, 2)) == 0) ? 10 : ((($urandom_range(0, 1)) == 0) ? 50 : 90);
      if ($urandom_range(0, 2) == 0) begin
        s = ls;
        c = lc;
      end else begin
        s = $urandom_range(0, 7);
        c = $urandom_range(0, 3);
      end
      ls = s;
      lc = c;
      step("rnd", 3'(s), 2'(c), 1'($urandom_range(0, 99) < rd_pct),
           1'($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)));
    end

    // reset with entries queued and a held report
    do_reset();
    for (int i = 0; i < 4; i++) step("mid", 3'(i + 1), 2'(i), 1'b0, 1'b0, 2'd0);
    check("mid.count4", 32'(rd_bus.count), 32'd4);
    do_reset();
    check("mid.cleared", 32'(rd_bus.count), 32'd0);
    step("mid", 3'd4, 2'd3, 1'b0, 1'b0, 2'd0);
    check("mid.reported", 32'(rd_bus.count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
